// File: rtl/sobel_ctrl_if.sv
// Datapath-side bus of sobel_ctrl: source-memory read port, 3x3 window to sobel_calc,
// sobel_calc result return, and result-memory write port.
interface sobel_ctrl_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [7:0]        rd_data_i;
   logic [7:0]        win_d0_o, win_d1_o, win_d2_o;
   logic [7:0]        win_d3_o, win_d4_o, win_d5_o;
   logic [7:0]        win_d6_o, win_d7_o, win_d8_o;
   logic              win_valid_o;
   logic [7:0]        calc_pix_i;
   logic              calc_valid_i;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [7:0]        wr_data_o;

   modport master (
      output rd_en_o, rd_addr_o,
      output win_d0_o, win_d1_o, win_d2_o, win_d3_o, win_d4_o, win_d5_o,
      output win_d6_o, win_d7_o, win_d8_o, win_valid_o,
      output wr_en_o, wr_addr_o, wr_data_o,
      input  rd_data_i, calc_pix_i, calc_valid_i
   );

   modport slave (
      input  rd_en_o, rd_addr_o,
      input  win_d0_o, win_d1_o, win_d2_o, win_d3_o, win_d4_o, win_d5_o,
      input  win_d6_o, win_d7_o, win_d8_o, win_valid_o,
      input  wr_en_o, wr_addr_o, wr_data_o,
      output rd_data_i, calc_pix_i, calc_valid_i
   );
endinterface

// File: rtl/sobel_ctrl.sv
// Frame sequencer for sobel_calc: raster-reads the source frame, builds 3x3 windows from two
// line buffers, and writes results back. Define SOBEL_CTRL_PERF_EN to add the cyc_cnt_o counter.
module sobel_ctrl #(
   parameter int unsigned IMG_W    = 64,
   parameter int unsigned IMG_H    = 64,
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned CALC_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
`ifdef SOBEL_CTRL_PERF_EN
   output logic [31:0] cyc_cnt_o,
`endif
   sobel_ctrl_if.master bus
);

   localparam int unsigned CW   = $clog2(IMG_W);
   localparam int unsigned RW   = $clog2(IMG_H);
   localparam int unsigned NPix = IMG_W * IMG_H;
   localparam int unsigned NOut = (IMG_W - 2) * (IMG_H - 2);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, wr_cnt_q, wr_addr_q;
   logic [CW-1:0]     col_q, arr_col_q;
   logic [RW-1:0]     row_q, arr_row_q;
   logic              arr_vld_q, win_valid_q, wr_en_q;
   logic [7:0]        wr_data_q;
   logic [7:0]        lb0_q [IMG_W];
   logic [7:0]        lb1_q [IMG_W];
   logic [2:0][7:0]   c1_q, c2_q, col_new;
   logic [8:0][7:0]   win_q;
   logic              start_acc, last_rd, win_hit;

   // Pipeline timing is set by sobel_calc itself; the write counter closes the frame.
   logic unused_calc_lat;
   assign unused_calc_lat = ^CALC_LAT;

   assign start_acc = (state_q == StIdle) && start_i;
   assign last_rd   = (state_q == StRead) && (rd_addr_q == ADDR_W'(NPix - 1));

   always_comb begin
      state_d     = state_q;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      bus.rd_en_o = 1'b0;
      unique case (state_q)
         StIdle:  if (start_i) state_d = StRead;
         StRead: begin
            busy_o      = 1'b1;
            bus.rd_en_o = 1'b1;
            if (last_rd) state_d = StDrain;
         end
         StDrain: begin
            busy_o = 1'b1;
            if (wr_cnt_q == ADDR_W'(NOut)) state_d = StDone;
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   // Read-side raster counters; all return to zero after the last read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_addr_q <= '0;
         col_q     <= '0;
         row_q     <= '0;
      end else if (state_q == StRead) begin
         if (last_rd) begin
            rd_addr_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
         end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
            if (col_q == CW'(IMG_W - 1)) begin
               col_q <= '0;
               row_q <= row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         arr_vld_q <= 1'b0;
         arr_col_q <= '0;
         arr_row_q <= '0;
      end else begin
         arr_vld_q <= bus.rd_en_o;
         arr_col_q <= col_q;
         arr_row_q <= row_q;
      end
   end

   // Index 0 = row r-2 (line buffer 1), 1 = row r-1 (line buffer 0), 2 = row r (memory).
   assign col_new = {bus.rd_data_i, lb0_q[arr_col_q], lb1_q[arr_col_q]};
   assign win_hit = arr_vld_q && (arr_row_q >= RW'(2)) && (arr_col_q >= CW'(2));

   always_ff @(posedge clk) begin
      if (arr_vld_q) begin
         lb0_q[arr_col_q] <= bus.rd_data_i;
         lb1_q[arr_col_q] <= lb0_q[arr_col_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         c1_q        <= '0;
         c2_q        <= '0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
      end else begin
         win_valid_q <= win_hit;
         if (arr_vld_q) begin
            c1_q <= col_new;
            c2_q <= c1_q;
         end
         if (win_hit) begin
            win_q <= {col_new[2], c1_q[2], c2_q[2],
                      col_new[1], c1_q[1], c2_q[1],
                      col_new[0], c1_q[0], c2_q[0]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_cnt_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (start_acc) begin
            wr_cnt_q <= '0;
         end else if (bus.calc_valid_i && busy_o) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_cnt_q;
            wr_data_q <= bus.calc_pix_i;
            wr_cnt_q  <= wr_cnt_q + 1'b1;
         end
      end
   end

`ifdef SOBEL_CTRL_PERF_EN
   logic [31:0] cyc_q;
   always_ff @(posedge clk) begin
      if (!rst)          cyc_q <= '0;
      else if (start_acc) cyc_q <= '0;
      else if (busy_o)    cyc_q <= cyc_q + 32'd1;
   end
   assign cyc_cnt_o = cyc_q;
`endif

   assign bus.rd_addr_o   = rd_addr_q;
   assign bus.win_d0_o    = win_q[0];
   assign bus.win_d1_o    = win_q[1];
   assign bus.win_d2_o    = win_q[2];
   assign bus.win_d3_o    = win_q[3];
   assign bus.win_d4_o    = win_q[4];
   assign bus.win_d5_o    = win_q[5];
   assign bus.win_d6_o    = win_q[6];
   assign bus.win_d7_o    = win_q[7];
   assign bus.win_d8_o    = win_q[8];
   assign bus.win_valid_o = win_valid_q;
   assign bus.wr_en_o     = wr_en_q;
   assign bus.wr_addr_o   = wr_addr_q;
   assign bus.wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_sobel_ctrl.sv
// Bench for sobel_ctrl on a 4x4 frame: source memory and sobel_calc stand-in models, with
// window/write scoreboards fed from a reference frame. Honours SOBEL_CTRL_PERF_EN.
module tb_sobel_ctrl;
   localparam int unsigned W   = 4;
   localparam int unsigned H   = 4;
   localparam int unsigned AW  = 12;
   localparam int unsigned LAT = 4;
   localparam int unsigned N   = W * H;
   localparam int unsigned NO  = (W - 2) * (H - 2);

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy, done;
   logic inj_valid;
   logic [31:0] cyc_cnt;

   sobel_ctrl_if #(.ADDR_W(AW)) bus ();

   sobel_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CALC_LAT(LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .busy_o  (busy),
      .done_o  (done),
`ifdef SOBEL_CTRL_PERF_EN
      .cyc_cnt_o (cyc_cnt),
`endif
      .bus     (bus)
   );

`ifndef SOBEL_CTRL_PERF_EN
   assign cyc_cnt = '0;
`endif

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int exp_rd, rd_cnt, win_cnt, wr_idx, done_cnt;
   int last_rd_cyc, last_wr_cyc, done_cyc;
   logic [7:0]  frame [N];
   logic [71:0] win_q [$];
   logic [7:0]  wr_q [$];

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stand-in for sobel_calc: position-weighted hash so tap order matters.
   function automatic logic [7:0] calc_f(input logic [71:0] w);
      int s = 0;
      for (int i = 0; i < 9; i++) s += int'(w[8*i +: 8]) * (i + 1);
      return 8'(s) ^ 8'hA5;
   endfunction

   function automatic logic [71:0] ref_win(input int r, input int c);
      logic [71:0] w = '0;
      for (int rr = 0; rr < 3; rr++)
         for (int cc = 0; cc < 3; cc++)
            w[8*(rr*3+cc) +: 8] = frame[(r-2+rr)*W + (c-2+cc)];
      return w;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= frame[bus.rd_addr_o[3:0]];

   logic [LAT-1:0] pv;
   logic [7:0]     pd [LAT];
   logic [71:0]    win_vec;
   assign win_vec = {bus.win_d8_o, bus.win_d7_o, bus.win_d6_o, bus.win_d5_o, bus.win_d4_o,
                     bus.win_d3_o, bus.win_d2_o, bus.win_d1_o, bus.win_d0_o};
   always @(posedge clk) begin
      if (!rst) pv <= '0;
      else      pv <= {pv[LAT-2:0], bus.win_valid_o};
      pd[0] <= calc_f(win_vec);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end
   assign bus.calc_valid_i = pv[LAT-1] | inj_valid;
   assign bus.calc_pix_i   = pd[LAT-1];

   always @(negedge clk) begin
      if (bus.rd_en_o) begin
         chk("rd_addr", 72'(bus.rd_addr_o), 72'(exp_rd));
         exp_rd++;
         rd_cnt++;
         last_rd_cyc = cyc;
      end
      if (bus.win_valid_o) begin
         win_cnt++;
         if (win_q.size() > 0) chk("window", win_vec, win_q.pop_front());
         else                  chk("win_extra", 72'(win_q.size()), 72'(1));
      end
      if (bus.wr_en_o) begin
         last_wr_cyc = cyc;
         chk("wr_addr", 72'(bus.wr_addr_o), 72'(wr_idx));
         if (wr_q.size() > 0) chk("wr_data", 72'(bus.wr_data_o), 72'(wr_q.pop_front()));
         else                 chk("wr_extra", 72'(wr_q.size()), 72'(1));
         wr_idx++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic load_frame(input int mode);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0:       frame[i] = 8'd50;
            1:       frame[i] = (i % W < 2) ? 8'd0 : 8'd100;
            2:       frame[i] = 8'(i * 13 + 7);
            default: frame[i] = 8'($urandom);
         endcase
      end
   endtask

   task automatic start_frame();
      exp_rd = 0; rd_cnt = 0; win_cnt = 0; wr_idx = 0; done_cnt = 0;
      for (int r = 2; r < H; r++)
         for (int c = 2; c < W; c++) begin
            win_q.push_back(ref_win(r, c));
            wr_q.push_back(calc_f(ref_win(r, c)));
         end
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("busy_after_start", 72'(busy), 72'(1));
   endtask

   task automatic finish_frame(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_seen"}, 72'(done_cnt != 0), 72'(1));
      repeat (3) @(negedge clk);
      chk({tag, "_done_pulses"}, 72'(done_cnt), 72'(1));
      chk({tag, "_reads"}, 72'(rd_cnt), 72'(N));
      chk({tag, "_windows"}, 72'(win_cnt), 72'(NO));
      chk({tag, "_writes"}, 72'(wr_idx), 72'(NO));
      chk({tag, "_win_q_left"}, 72'(win_q.size()), 72'(0));
      chk({tag, "_wr_q_left"}, 72'(wr_q.size()), 72'(0));
      chk({tag, "_done_after_wr"}, 72'(done_cyc - last_wr_cyc), 72'(1));
      chk({tag, "_idle_busy"}, 72'(busy), 72'(0));
`ifdef SOBEL_CTRL_PERF_EN
      chk({tag, "_cyc_cnt"}, 72'(cyc_cnt), 72'(N + 3 + LAT));
`endif
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 72'(busy), 72'(0));
      chk({tag, "_done"}, 72'(done), 72'(0));
      chk({tag, "_rd"}, 72'({bus.rd_en_o, bus.rd_addr_o}), 72'(0));
      chk({tag, "_win"}, {win_vec[70:0], bus.win_valid_o}, 72'(0));
      chk({tag, "_wr"}, 72'({bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o}), 72'(0));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; inj_valid = 1'b0;
      bus.rd_data_i = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      load_frame(0);
      start_frame();
      finish_frame("flat50");

      load_frame(1);
      start_frame();
      finish_frame("edge");

      load_frame(2);
      start_frame();
      finish_frame("ramp");
      chk("ramp_latency", 72'(last_wr_cyc - last_rd_cyc), 72'(LAT + 3));

      load_frame(3);
      start_frame();
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      finish_frame("restart_ignored");

      // Stray result strobe while idle must not write or advance the counter.
      @(negedge clk) inj_valid = 1'b1;
      @(negedge clk) inj_valid = 1'b0;
      chk("idle_calc_valid_wr_en", 72'(bus.wr_en_o), 72'(0));
`ifdef SOBEL_CTRL_PERF_EN
      chk("cyc_cnt_hold", 72'(cyc_cnt), 72'(N + 3 + LAT));
`endif

      load_frame(2);
      start_frame();
      begin
         int n = 0;
         while (rd_cnt < 9 && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("reads_before_reset", 72'(rd_cnt >= 9), 72'(1));
      end
      rst = 1'b0;
      win_q.delete();
      wr_q.delete();
      @(negedge clk);
      chk_all_zero("midreset");
      rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("midreset_no_done", 72'(done_cnt), 72'(0));
      chk("midreset_no_write", 72'(wr_idx), 72'(0));

      load_frame(3);
      start_frame();
      finish_frame("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timed out");
   end
endmodule
